// File: rtl/rgb_fade_sequencer_if.sv
// rtl/rgb_fade_sequencer_if.sv - control and colour-output bundle for the RGB fade sequencer
interface rgb_fade_sequencer_if;
  logic       en;
  logic       next;
  logic [7:0] R_time;
  logic [7:0] G_time;
  logic [7:0] B_time;
  logic [2:0] cur_st;
  logic       busy;
  logic       seq_wrap;

  modport master (
    output en, next,
    input  R_time, G_time, B_time, cur_st, busy, seq_wrap
  );

  modport slave (
    input  en, next,
    output R_time, G_time, B_time, cur_st, busy, seq_wrap
  );
endinterface

// File: rtl/rgb_fade_sequencer.sv
// rtl/rgb_fade_sequencer.sv - steps PWM duty values through an 8-colour fade/hold cycle
module rgb_fade_sequencer #(
  parameter int STEP_DIV   = 50000,
  parameter int HOLD_STEPS = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  rgb_fade_sequencer_if.slave   bus
);

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(STEP_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS - 1);

  typedef enum logic [1:0] {IDLE, FADE, HOLD} state_t;
  typedef logic [2:0][7:0] rgb_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] pre_cnt;
  logic [HW-1:0] hold_cnt;
  logic [2:0]    cur_st;
  rgb_t          ch;
  rgb_t          tgt;
  rgb_t          stepped;
  logic          seq_wrap;

  logic active;
  logic tick;
  logic at_target;
  logic hold_last;
  logic advance;

  // Packed as {blue, green, red} so ch[0] is red.
  function automatic rgb_t target_of(input logic [2:0] idx);
    rgb_t t;
    case (idx)
      3'd0:    t = {8'h00, 8'h00, 8'hFF};
      3'd1:    t = {8'h00, 8'hFF, 8'hFF};
      3'd2:    t = {8'h00, 8'hFF, 8'h00};
      3'd3:    t = {8'hFF, 8'hFF, 8'h00};
      3'd4:    t = {8'hFF, 8'h00, 8'h00};
      3'd5:    t = {8'hFF, 8'h00, 8'hFF};
      3'd6:    t = {8'hFF, 8'hFF, 8'hFF};
      default: t = {8'h00, 8'h00, 8'h00};
    endcase
    return t;
  endfunction

  always_comb begin
    tgt = target_of(cur_st);
    for (int i = 0; i < 3; i++) begin
      if (ch[i] < tgt[i])
        stepped[i] = ch[i] + 8'd1;
      else if (ch[i] > tgt[i])
        stepped[i] = ch[i] - 8'd1;
      else
        stepped[i] = ch[i];
    end
    at_target = (stepped == tgt);
    active    = (state != IDLE);
    tick      = active && (pre_cnt == PRE_LAST);
    hold_last = (hold_cnt == HOLD_LAST);
    advance   = (state == HOLD) && bus.en && (bus.next || (tick && hold_last));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // en=0 outranks next, which outranks tick.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.en) state_nxt = FADE;
      FADE: begin
        if (!bus.en)
          state_nxt = IDLE;
        else if (bus.next || (tick && at_target))
          state_nxt = HOLD;
      end
      HOLD: begin
        if (!bus.en)
          state_nxt = IDLE;
        else if (advance)
          state_nxt = FADE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt  <= '0;
      hold_cnt <= '0;
      cur_st   <= 3'd0;
      ch       <= '0;
      seq_wrap <= 1'b0;
    end else begin
      seq_wrap <= advance && (cur_st == 3'd7);
      if (advance)
        cur_st <= cur_st + 3'd1;

      if ((state == FADE) && bus.en) begin
        if (bus.next)
          ch <= tgt;
        else if (tick)
          ch <= stepped;
      end

      if (!active || !bus.en || bus.next || tick)
        pre_cnt <= '0;
      else
        pre_cnt <= pre_cnt + PW'(1);

      // Held at zero outside HOLD so every hold starts from a full count.
      if ((state != HOLD) || !bus.en || bus.next)
        hold_cnt <= '0;
      else if (tick)
        hold_cnt <= hold_last ? '0 : hold_cnt + HW'(1);
    end
  end

  always_comb begin
    bus.busy     = (state == FADE);
    bus.R_time   = ch[0];
    bus.G_time   = ch[1];
    bus.B_time   = ch[2];
    bus.cur_st   = cur_st;
    bus.seq_wrap = seq_wrap;
  end

endmodule
